// File: rtl/key_debouncer_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // Bits needed to hold 0..limit-1, never less than one bit.
  function automatic int cnt_width(input int unsigned limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/key_debounce_one.sv
// One key: two-flop synchronizer, debounce FSM with counters, and registered
// level / press / release / repeat strobes.
module key_debounce_one
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_event
);

  localparam int          CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int          RW   = cnt_width(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

  logic          sync_p0, sync_p1;
  logic          pressed_s;
  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] tmr, tmr_nxt, tmr_inc, rep_target;
  logic          rep_started, rep_started_nxt;
  logic          level_nxt, press_nxt, release_nxt, repeat_nxt;

  assign pressed_s = ~sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0     <= 1'b1;
      sync_p1     <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      rep_started <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      key_event   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability filter on the raw pin
      sync_p0     <= key;
      sync_p1     <= sync_p0;
      // FSM stage: registered state, counters and strobes
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      tmr         <= tmr_nxt;
      rep_started <= rep_started_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_repeat  <= repeat_nxt;
      key_event   <= press_nxt | repeat_nxt;
    end
  end

  // The repeat timer restarts after every strobe, so it only ever counts up to
  // the current target and cannot wrap.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    tmr_nxt         = tmr;
    rep_started_nxt = rep_started;
    press_nxt       = 1'b0;
    release_nxt     = 1'b0;
    repeat_nxt      = 1'b0;
    tmr_inc         = tmr + RW'(1);
    rep_target      = rep_started ? R_PERIOD : R_DELAY;

    unique case (state)
      IDLE: begin
        if (pressed_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = PRESSED;
          press_nxt       = 1'b1;
          tmr_nxt         = '0;
          rep_started_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (REPEAT_EN != 0) begin
          if (tmr_inc == rep_target) begin
            repeat_nxt      = 1'b1;
            tmr_nxt         = '0;
            rep_started_nxt = 1'b1;
          end else begin
            tmr_nxt = tmr_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

endmodule

// File: rtl/key_debouncer.sv
// N independent push-button debouncers; keys share no state.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int          N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int          REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic [N_KEYS-1:0] key_event
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i]),
      .key_event  (key_event[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: a repeat-disabled and a repeat-enabled instance
// share the same pins and are compared each cycle against a run-length model.
module tb_key_debouncer;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] key;
  logic [2:0] lvl0, prs0, rel0, rep0, evt0;
  logic [2:0] lvl1, prs1, rel1, rep1, evt1;

  int checks   = 0;
  int failures = 0;

  key_debouncer #(
    .N_KEYS(3), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0),
    .key_repeat(rep0), .key_event(evt0)
  );

  key_debouncer #(
    .N_KEYS(3), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_level(lvl1), .key_press(prs1), .key_release(rel1),
    .key_repeat(rep1), .key_event(evt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a change is accepted once the synchronized value has differed
  // from the accepted level on DEB+1 consecutive samples. Hold time counts
  // samples taken while stably pressed; repeats fall at RDLY, RDLY+RPER, ...
  logic [2:0] m_sp0, m_sp1, m_lvl, m_press, m_rel, m_rep;
  int         m_run  [3];
  int         m_hold [3];
  wire  [2:0] m_s = ~m_sp1;

  function automatic bit is_repeat(input int t);
    return (t == RDLY) || ((t > RDLY) && (((t - RDLY) % RPER) == 0));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sp0   <= '1;
      m_sp1   <= '1;
      m_lvl   <= '0;
      m_press <= '0;
      m_rel   <= '0;
      m_rep   <= '0;
      for (int i = 0; i < 3; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      m_sp0 <= key;
      m_sp1 <= m_sp0;
      for (int i = 0; i < 3; i++) begin
        m_press[i] <= 1'b0;
        m_rel[i]   <= 1'b0;
        m_rep[i]   <= 1'b0;
        if (m_s[i] == m_lvl[i]) begin
          m_run[i] <= 0;
          if (m_lvl[i] && m_run[i] == 0) begin
            m_hold[i] <= m_hold[i] + 1;
            if (is_repeat(m_hold[i] + 1)) m_rep[i] <= 1'b1;
          end
        end else if (m_run[i] + 1 == DEB + 1) begin
          m_run[i] <= 0;
          m_lvl[i] <= m_s[i];
          if (m_s[i]) begin
            m_press[i] <= 1'b1;
            m_hold[i]  <= 0;
          end else begin
            m_rel[i] <= 1'b1;
          end
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("level0",   lvl0, m_lvl);
    chk("press0",   prs0, m_press);
    chk("release0", rel0, m_rel);
    chk("repeat0",  rep0, 3'b000);
    chk("event0",   evt0, m_press);
    chk("level1",   lvl1, m_lvl);
    chk("press1",   prs1, m_press);
    chk("release1", rel1, m_rel);
    chk("repeat1",  rep1, m_rep);
    chk("event1",   evt1, m_press | m_rep);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 3'b111;
    ticks(3);
    chk("reset_outputs0", lvl0 | prs0 | rel0 | rep0 | evt0, 3'b000);
    chk("reset_outputs1", lvl1 | prs1 | rel1 | rep1 | evt1, 3'b000);
    rst_n = 1'b1;
    ticks(3);

    // clean press and release on key 0
    key[0] = 1'b0;
    ticks(6);
    chk("clean_press_early", prs0, 3'b000);
    tick();
    chk("clean_press", prs0, 3'b001);
    ticks(20);
    chk("clean_level", lvl0, 3'b001);
    key[0] = 1'b1;
    ticks(7);
    chk("clean_release", rel0, 3'b001);
    tick();
    chk("clean_level_off", lvl0, 3'b000);
    ticks(4);

    // press bounce on key 1
    key[1] = 1'b0; ticks(3);
    key[1] = 1'b1; ticks(1);
    key[1] = 1'b0; ticks(2);
    key[1] = 1'b1; ticks(10);
    chk("bounce_level", lvl0, 3'b000);

    // release bounce on key 1
    key[1] = 1'b0; ticks(9);
    key[1] = 1'b1; ticks(2);
    key[1] = 1'b0; ticks(10);
    chk("rel_bounce_level", lvl0, 3'b010);
    key[1] = 1'b1; ticks(10);

    // auto-repeat on key 2
    key[2] = 1'b0; ticks(7);
    chk("repeat_press", prs1, 3'b100);
    ticks(10);
    chk("repeat_first", rep1, 3'b100);
    ticks(3);
    chk("repeat_second", evt1, 3'b100);
    ticks(20);
    key[2] = 1'b1; ticks(10);

    // reset while in PRESS_WAIT, pin still held afterwards
    key[0] = 1'b0; ticks(4);
    rst_n = 1'b0; ticks(2);
    chk("midreset_outputs", lvl1 | prs1 | rel1 | rep1 | evt1, 3'b000);
    rst_n = 1'b1;
    ticks(6);
    chk("midreset_no_early", prs0, 3'b000);
    tick();
    chk("midreset_press", prs0, 3'b001);
    key[0] = 1'b1; ticks(10);

    // simultaneous press of keys 0 and 2
    key = 3'b010;
    ticks(7);
    chk("simul_press", prs0, 3'b101);
    key = 3'b111;
    ticks(10);

    // randomized pins: fast chatter first, then long holds, rare resets
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, (c < 1200) ? 5 : 40) == 0) key[i] = ~key[i];
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    ticks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
